// File: rtl/uart_tx_ctrl_if.sv
// Bus/transmitter-side signal bundle for uart_tx_ctrl.
//   slave  : the controller (takes bus config/writes and i_tx_busy, drives
//            FIFO status and the transmitter-facing outputs)
//   master : whoever drives the controller (bus side + transmitter model)
interface uart_tx_ctrl_if #(
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             i_enable;
  logic [DIV_W-1:0] i_div;
  logic [1:0]       i_length;
  logic             i_stop2;
  logic             i_parity;
  logic             i_odd;
  logic             i_wr;
  logic [8:0]       i_wdata;
  logic             i_clr_ovf;
  logic             o_full;
  logic             o_empty;
  logic [CW-1:0]    o_count;
  logic             o_overflow;
  logic             o_idle;
  logic             o_tx_ce;
  logic [8:0]       o_tx_data;
  logic [1:0]       o_tx_length;
  logic             o_tx_stop2;
  logic             o_tx_parity;
  logic             o_tx_odd;
  logic             o_tx_start;
  logic             i_tx_busy;

  modport slave (
    input  i_enable, i_div, i_length, i_stop2, i_parity, i_odd,
           i_wr, i_wdata, i_clr_ovf, i_tx_busy,
    output o_full, o_empty, o_count, o_overflow, o_idle, o_tx_ce,
           o_tx_data, o_tx_length, o_tx_stop2, o_tx_parity, o_tx_odd,
           o_tx_start
  );

  modport master (
    output i_enable, i_div, i_length, i_stop2, i_parity, i_odd,
           i_wr, i_wdata, i_clr_ovf, i_tx_busy,
    input  o_full, o_empty, o_count, o_overflow, o_idle, o_tx_ce,
           o_tx_data, o_tx_length, o_tx_stop2, o_tx_parity, o_tx_odd,
           o_tx_start
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: baud tick generator, character FIFO and the
// frame-issue FSM that feeds the transmitter back-to-back frames.
// Ports:
//   i_clk, i_rst : clock, async active-high reset
//   bus          : uart_tx_ctrl_if.slave (config, FIFO write/status,
//                  transmitter tick/start/data/config and busy)
module uart_tx_ctrl #(
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  uart_tx_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {C_IDLE, C_ISSUE, C_WAIT} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt;
  logic             tx_ce;
  logic [8:0]       mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop, load, ovf;
  logic             tx_start, tx_stop2, tx_par, tx_odd;
  logic [8:0]       tx_data;
  logic [1:0]       tx_len;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = bus.i_wr && !full;
  // The transmitter samples start on the tick, so the entry is consumed then.
  assign pop   = (state == C_ISSUE) && tx_ce;

  // Baud divider: held at reload value while disabled, so the first tick
  // after enable comes a full period later.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt   <= '0;
      tx_ce <= 1'b0;
    end else if (!bus.i_enable) begin
      cnt   <= bus.i_div;
      tx_ce <= 1'b0;
    end else if (cnt == '0) begin
      cnt   <= bus.i_div;
      tx_ce <= 1'b1;
    end else begin
      cnt   <= cnt - 1'b1;
      tx_ce <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr] <= bus.i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A dropped write sets the flag even if a pop frees space this cycle.
      if (bus.i_wr && full)  ovf <= 1'b1;
      else if (bus.i_clr_ovf) ovf <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      C_IDLE:
        if (bus.i_enable && !empty) begin
          load      = 1'b1;
          state_nxt = C_ISSUE;
        end
      C_ISSUE:
        if (tx_ce) state_nxt = C_WAIT;
      // Busy low means the transmitter is in its stop bit (or idle); issuing
      // now lets the next start land on the tick that ends the stop bit.
      C_WAIT:
        if (!bus.i_tx_busy) begin
          if (bus.i_enable && !empty) begin
            load      = 1'b1;
            state_nxt = C_ISSUE;
          end else begin
            state_nxt = C_IDLE;
          end
        end
      default: state_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= C_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      tx_len   <= '0;
      tx_stop2 <= 1'b0;
      tx_par   <= 1'b0;
      tx_odd   <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_start <= (state_nxt == C_ISSUE);
      // Data and frame config only move on entry to C_ISSUE.
      if (load) begin
        tx_data  <= mem[rptr];
        tx_len   <= bus.i_length;
        tx_stop2 <= bus.i_stop2;
        tx_par   <= bus.i_parity;
        tx_odd   <= bus.i_odd;
      end
    end
  end

  assign bus.o_full      = full;
  assign bus.o_empty     = empty;
  assign bus.o_count     = count;
  assign bus.o_overflow  = ovf;
  assign bus.o_idle      = (state == C_IDLE) && empty && !bus.i_tx_busy;
  assign bus.o_tx_ce     = tx_ce;
  assign bus.o_tx_data   = tx_data;
  assign bus.o_tx_length = tx_len;
  assign bus.o_tx_stop2  = tx_stop2;
  assign bus.o_tx_parity = tx_par;
  assign bus.o_tx_odd    = tx_odd;
  assign bus.o_tx_start  = tx_start;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: transaction-level reference model (queue FIFO,
// phase tracker), a tick-counting transmitter model driving i_tx_busy, a
// per-cycle output compare, and directed scenarios with literal checks.
module tb_uart_tx_ctrl;
  localparam int DEPTH = 4;
  localparam int DIV_W = 16;
  localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DEPTH(DEPTH), .DIV_W(DIV_W)) bus();
  uart_tx_ctrl #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus.slave)
  );

  int errs = 0, checks = 0;

  // transmitter model
  logic tx_busy = 1'b0;
  int   left = 0, ticks = 0;
  logic s_ce = 1'b0, s_start = 1'b0;
  int   s_frame = 0;
  assign bus.i_tx_busy = tx_busy;

  // reference model
  logic [8:0]       q[$];
  logic [8:0]       acc[$];
  logic [DIV_W-1:0] m_cnt = '0;
  logic             m_ce = 1'b0, m_ovf = 1'b0;
  int               m_ph = P_IDLE;
  logic [8:0]       m_data = '0;
  logic [1:0]       m_len = '0;
  logic             m_s2 = 1'b0, m_par = 1'b0, m_odd = 1'b0;

  // frames actually started on the transmitter
  logic [8:0] sent_data[$];
  logic       sent_par[$];
  logic [1:0] sent_len[$];
  int         sent_tick[$];
  int         n_sent = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: tick every div+1 enabled clocks; FIFO as a queue; a character is
  // latched when issue begins, leaves the queue on the tick that starts it,
  // and the next one is issued once the transmitter reports not-busy.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= '0; m_ce <= 1'b0; m_ovf <= 1'b0; m_ph <= P_IDLE;
      m_data <= '0; m_len <= '0; m_s2 <= 1'b0; m_par <= 1'b0; m_odd <= 1'b0;
      q.delete();
    end else begin
      if (!bus.i_enable)    begin m_cnt <= bus.i_div; m_ce <= 1'b0; end
      else if (m_cnt == 0)  begin m_cnt <= bus.i_div; m_ce <= 1'b1; end
      else                  begin m_cnt <= m_cnt - 1'b1; m_ce <= 1'b0; end
      if (bus.i_wr && q.size() == DEPTH) m_ovf <= 1'b1;
      else if (bus.i_clr_ovf)            m_ovf <= 1'b0;
      if ((m_ph == P_IDLE || (m_ph == P_WAIT && !tx_busy)) && bus.i_enable && q.size() != 0) begin
        m_ph <= P_ISSUE; m_data <= q[0]; m_len <= bus.i_length;
        m_s2 <= bus.i_stop2; m_par <= bus.i_parity; m_odd <= bus.i_odd;
      end else if (m_ph == P_WAIT && !tx_busy) begin
        m_ph <= P_IDLE;
      end else if (m_ph == P_ISSUE && m_ce) begin
        m_ph <= P_WAIT;
      end
      if (bus.i_wr && q.size() < DEPTH) begin
        q.push_back(bus.i_wdata);
        acc.push_back(bus.i_wdata);
      end
      if (m_ph == P_ISSUE && m_ce) void'(q.pop_front());
    end
  end

  // Transmitter: takes start on a tick while not busy; stays busy through
  // start, data and parity bits (and the first of two stop bits), so the
  // last stop bit runs with busy low.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy <= 1'b0; left <= 0; ticks <= 0;
    end else if (s_ce) begin
      ticks <= ticks + 1;
      if (tx_busy) begin
        left <= left - 1;
        if (left == 1) tx_busy <= 1'b0;
      end else if (s_start) begin
        tx_busy <= 1'b1;
        left    <= s_frame;
      end
    end
  end

  task automatic write_chars(input logic [8:0] d[$]);
    foreach (d[i]) begin
      bus.i_wr = 1'b1; bus.i_wdata = d[i];
      @(negedge clk);
    end
    bus.i_wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    while (bus.o_idle !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(bus.o_idle), 1);
  endtask

  initial begin
    bus.i_enable = 1'b0; bus.i_div = 16'd3; bus.i_length = 2'd0;
    bus.i_stop2 = 1'b0; bus.i_parity = 1'b0; bus.i_odd = 1'b0;
    bus.i_wr = 1'b0; bus.i_wdata = '0; bus.i_clr_ovf = 1'b0;
    fork
      begin : stim
        int last, nce, b, hits, hold, i;
        logic [7:0] seq[$];
        logic [7:0] prev;
        repeat (3) @(negedge clk);
        check("rst_idle",  32'(bus.o_idle), 1);
        check("rst_empty", 32'(bus.o_empty), 1);
        check("rst_count", 32'(bus.o_count), 0);
        check("rst_start", 32'(bus.o_tx_start), 0);
        check("rst_ce",    32'(bus.o_tx_ce), 0);
        check("rst_ovf",   32'(bus.o_overflow), 0);
        rst = 1'b0;

        // tick period with div=3
        bus.i_enable = 1'b1;
        last = -1; nce = 0;
        for (int k = 0; k < 16; k++) begin
          @(negedge clk);
          if (bus.o_tx_ce) begin
            if (last >= 0) check("tick_gap", 32'(k - last), 4);
            last = k; nce++;
          end
        end
        check("tick_count", 32'(nce), 4);
        check("t1_idle", 32'(bus.o_idle), 1);
        check("t1_empty", 32'(bus.o_empty), 1);

        // single frame 0x55, length code 2
        bus.i_length = 2'd2;
        b = sent_data.size();
        write_chars('{9'h055});
        i = 0;
        while (sent_data.size() == b && i < 100) begin @(negedge clk); i++; end
        check("f55_started", 32'(sent_data.size() - b), 1);
        check("f55_data", 32'(sent_data[b]), 32'h55);
        check("f55_len",  32'(sent_len[b]), 2);
        wait_idle(200, "f55_idle");

        // three queued frames, div=0
        bus.i_enable = 1'b0; bus.i_div = 16'd0; bus.i_length = 2'd0;
        @(negedge clk);
        b = sent_data.size();
        write_chars('{9'h001, 9'h002, 9'h003});
        check("three_count", 32'(bus.o_count), 3);
        bus.i_enable = 1'b1;
        prev = 8'(bus.o_count);
        seq.push_back(prev);
        for (int k = 0; k < 300 && prev != 0; k++) begin
          @(negedge clk);
          if (8'(bus.o_count) != prev) begin
            prev = 8'(bus.o_count);
            seq.push_back(prev);
          end
        end
        check("count_seq_len", 32'(seq.size()), 4);
        check("count_seq", {seq[0], seq[1], seq[2], seq[3]}, 32'h03020100);
        wait_idle(300, "three_idle");
        check("three_frames", 32'(sent_data.size() - b), 3);

        // overflow: fill 4 while disabled, fifth is dropped
        bus.i_enable = 1'b0; bus.i_div = 16'd1;
        @(negedge clk);
        write_chars('{9'h010, 9'h011, 9'h012, 9'h013, 9'h0AA});
        check("ovf_full",  32'(bus.o_full), 1);
        check("ovf_flag",  32'(bus.o_overflow), 1);
        check("ovf_count", 32'(bus.o_count), 4);
        bus.i_clr_ovf = 1'b1;
        @(negedge clk);
        bus.i_clr_ovf = 1'b0;
        check("ovf_cleared", 32'(bus.o_overflow), 0);
        bus.i_enable = 1'b1;
        wait_idle(600, "ovf_idle");
        hits = 0;
        foreach (sent_data[k]) if (sent_data[k] == 9'h0AA) hits++;
        check("aa_never_sent", 32'(hits), 0);

        // parity change mid-frame, back-to-back gap of one stop tick
        b = sent_data.size();
        write_chars('{9'h021, 9'h022});
        i = 0;
        while (sent_data.size() == b && i < 100) begin @(negedge clk); i++; end
        bus.i_parity = 1'b1;
        wait_idle(400, "par_idle");
        check("par_frames", 32'(sent_data.size() - b), 2);
        check("par_first",  32'(sent_par[b]), 0);
        check("par_second", 32'(sent_par[b+1]), 1);
        check("b2b_gap_ticks", 32'(sent_tick[b+1] - sent_tick[b]), 8);
        bus.i_parity = 1'b0;

        // enable dropped while issuing
        bus.i_enable = 1'b0; bus.i_div = 16'd7;
        @(negedge clk);
        write_chars('{9'h05A});
        bus.i_enable = 1'b1;
        @(negedge clk);
        bus.i_enable = 1'b0;
        check("hold_start", 32'(bus.o_tx_start), 1);
        hold = 0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (bus.o_tx_start && !bus.o_tx_ce && bus.o_count == 1) hold++;
        end
        check("hold_cycles", 32'(hold), 10);
        bus.i_enable = 1'b1;
        i = 0;
        while (bus.o_count != 0 && i < 40) begin @(negedge clk); i++; end
        check("reenable_latency", 32'(i), 9);
        wait_idle(300, "end_idle");
        check("all_frames_sent", 32'(n_sent), 32'(acc.size()));
      end
      begin : cmp
        forever begin
          @(negedge clk);
          check("cycle_outputs",
                {bus.o_tx_ce, bus.o_tx_start, bus.o_count, bus.o_empty, bus.o_full,
                 bus.o_overflow, bus.o_idle, bus.o_tx_data, bus.o_tx_length,
                 bus.o_tx_stop2, bus.o_tx_parity, bus.o_tx_odd},
                {m_ce, m_ph == P_ISSUE, 3'(q.size()), q.size() == 0, q.size() == DEPTH,
                 m_ovf, (m_ph == P_IDLE) && q.size() == 0 && !tx_busy, m_data, m_len,
                 m_s2, m_par, m_odd});
          s_ce    = bus.o_tx_ce;
          s_start = bus.o_tx_start;
          s_frame = 7 + int'(bus.o_tx_length) + int'(bus.o_tx_parity) + int'(bus.o_tx_stop2);
          if (!rst && bus.o_tx_ce && bus.o_tx_start && !tx_busy) begin
            sent_data.push_back(bus.o_tx_data);
            sent_par.push_back(bus.o_tx_parity);
            sent_len.push_back(bus.o_tx_length);
            sent_tick.push_back(ticks);
            check("frame_expected", 32'(acc.size() > n_sent), 1);
            if (acc.size() > n_sent) check("frame_order", 32'(bus.o_tx_data), 32'(acc[n_sent]));
            n_sent++;
          end
        end
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
